// File: rtl/slot_dac_serializer_pkg.sv
// Shared definitions for the slot DAC serializer: fetch FSM encoding,
// I2S frame geometry and the FIFO occupancy width.
package slot_dac_serializer_pkg;

    localparam int BITS_PER_CHANNEL = 32;
    localparam int SAMPLE_BITS      = 24;
    localparam int BYTES_PER_FRAME  = 6;
    localparam int FIFO_COUNT_W     = 11;

    localparam int FRAME_BITS = 2 * BITS_PER_CHANNEL;
    localparam int STAGE_BITS = 2 * SAMPLE_BITS;
    localparam int PAD_BITS   = BITS_PER_CHANNEL - SAMPLE_BITS;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        FETCH,
        HOLD
    } fetch_state_t;

    // Staged {L, R} samples laid out as one frame: each sample MSB first,
    // followed by its trailing zero pad.
    function automatic logic [FRAME_BITS-1:0] frame_word(input logic [STAGE_BITS-1:0] s);
        return {s[STAGE_BITS-1:SAMPLE_BITS], {PAD_BITS{1'b0}},
                s[SAMPLE_BITS-1:0], {PAD_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/slot_bclk_divider.sv
// Bit-clock generator: toggles bclk every CLK_DIV clk cycles while run is high
// and reports the edge it is about to make as one-clk rise/fall strobes.
module slot_bclk_divider #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic bclk,
    output logic rise,
    output logic fall
);

    logic [7:0] cnt;
    logic       tick;

    // Strobes are high in the clk whose rising edge flips bclk.
    assign tick = run && (cnt == 8'(CLK_DIV - 1));
    assign rise = tick && !bclk;
    assign fall = tick && bclk;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            bclk <= 1'b0;
        end else if (!run) begin
            cnt  <= '0;
            bclk <= 1'b0;
        end else if (tick) begin
            cnt  <= '0;
            bclk <= ~bclk;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/slot_dac_serializer.sv
// I2S DAC serializer: fetches 6 bytes per frame from a tracking FIFO into a
// staging buffer while the previous frame shifts out, zero-filling on underrun.
module slot_dac_serializer
    import slot_dac_serializer_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int MIN_BYTES = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [7:0]              fifo_data,
    input  logic [FIFO_COUNT_W-1:0] fifo_count,
    output logic                    fifo_read,
    output logic                    dac_bclk,
    output logic                    dac_lrck,
    output logic                    dac_sdata,
    output logic                    underrun,
    input  logic                    underrun_clr
);

    fetch_state_t          state;
    fetch_state_t          state_next;
    logic [2:0]            fetch_cnt;
    logic [STAGE_BITS-1:0] staging;
    logic [FRAME_BITS-1:0] shift_reg;
    logic [5:0]            bit_cnt;
    logic                  run;
    logic                  bclk_rise;
    logic                  bclk_fall;
    logic                  boundary;
    logic                  launch;
    logic                  zero_fill;
    logic                  capture;

    slot_bclk_divider #(
        .CLK_DIV(CLK_DIV)
    ) u_bclk_divider (
        .clk  (clk),
        .reset(reset),
        .run  (run),
        .bclk (dac_bclk),
        .rise (bclk_rise),
        .fall (bclk_fall)
    );

    // bit_cnt counts bclk rises in the frame and wraps to 0 on the 64th,
    // so the falling edge that follows closes the frame.
    assign boundary = run && bclk_fall && (bit_cnt == 6'd0);
    assign launch   = (state == HOLD) && enable && (!run || boundary);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        fifo_read  = 1'b0;
        zero_fill  = 1'b0;
        capture    = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable) state_next = CHECK;
            end
            CHECK: begin
                if (fifo_count >= FIFO_COUNT_W'(MIN_BYTES)) begin
                    state_next = FETCH;
                end else begin
                    zero_fill  = 1'b1;
                    state_next = HOLD;
                end
            end
            FETCH: begin
                // Six read strobes, each byte captured the clk after its strobe.
                fifo_read = (fetch_cnt < 3'(BYTES_PER_FRAME));
                capture   = (fetch_cnt != 3'd0);
                if (fetch_cnt == 3'(BYTES_PER_FRAME)) state_next = HOLD;
            end
            HOLD: begin
                if (!run || boundary) state_next = enable ? CHECK : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_cnt <= '0;
            staging   <= '0;
            underrun  <= 1'b0;
        end else begin
            fetch_cnt <= (state == FETCH) ? fetch_cnt + 3'd1 : 3'd0;
            if (zero_fill)    staging <= '0;
            else if (capture) staging <= {staging[STAGE_BITS-9:0], fifo_data};
            if (zero_fill)         underrun <= 1'b1;
            else if (underrun_clr) underrun <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run       <= 1'b0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            dac_lrck  <= 1'b0;
            dac_sdata <= 1'b0;
        end else if (launch) begin
            run       <= 1'b1;
            bit_cnt   <= '0;
            shift_reg <= frame_word(staging);
            dac_lrck  <= 1'b0;
            dac_sdata <= 1'b0;
        end else if (boundary) begin
            // Nothing staged in time (or enable dropped): send silence or stop.
            run       <= enable;
            bit_cnt   <= '0;
            shift_reg <= '0;
            dac_lrck  <= 1'b0;
            dac_sdata <= 1'b0;
        end else begin
            if (bclk_rise) bit_cnt <= bit_cnt + 6'd1;
            if (bclk_fall) begin
                // Slot k carries frame bit k-1: the one-bclk I2S delay.
                dac_lrck  <= bit_cnt[5];
                dac_sdata <= shift_reg[FRAME_BITS-1];
                shift_reg <= {shift_reg[FRAME_BITS-2:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_slot_dac_serializer.sv
// Self-checking bench for slot_dac_serializer: FIFO model, I2S receiver with
// an expected-frame queue, a vector table and hand-written corner sequences.
module tb_slot_dac_serializer;

    localparam int CLK_DIV  = 4;
    localparam int MEM_SIZE = 36;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        underrun_clr;
    logic [7:0]  fifo_data = 8'h00;
    logic [10:0] fifo_count;
    logic        fifo_read;
    logic        dac_bclk;
    logic        dac_lrck;
    logic        dac_sdata;
    logic        underrun;

    always #5 clk = ~clk;

    slot_dac_serializer #(
        .CLK_DIV  (CLK_DIV),
        .MIN_BYTES(6)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .fifo_data   (fifo_data),
        .fifo_count  (fifo_count),
        .fifo_read   (fifo_read),
        .dac_bclk    (dac_bclk),
        .dac_lrck    (dac_lrck),
        .dac_sdata   (dac_sdata),
        .underrun    (underrun),
        .underrun_clr(underrun_clr)
    );

    // FIFO model: data valid one clk after the read strobe.
    logic [7:0]  mem [MEM_SIZE];
    int          rd_ptr    = 0;
    int          fill      = 0;
    bit          ptr_clr   = 1'b0;
    bit          use_ovr   = 1'b1;
    logic [10:0] count_ovr = 11'd0;

    assign fifo_count = use_ovr ? count_ovr : 11'(fill - rd_ptr);

    always @(posedge clk) begin
        if (ptr_clr) begin
            rd_ptr <= 0;
        end else if (fifo_read) begin
            fifo_data <= mem[rd_ptr % MEM_SIZE];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    // I2S receiver and read monitor, sampled on the falling clk edge.
    logic [47:0] exp_q[$];
    int   read_cnt    = 0;
    int   run_len     = 0;
    int   frames_done = 0;
    int   slot        = 0;
    int   gap         = 0;
    int   idle_cnt    = 0;
    int   edge_viol   = 0;
    logic prev_bclk   = 1'b0;
    logic prev_lrck   = 1'b0;
    logic prev_sdata  = 1'b0;
    logic sd [64];
    logic lr [64];

    task automatic frame_done();
        logic [23:0] l;
        logic [23:0] r;
        logic        fmt_ok;
        fmt_ok = 1'b1;
        for (int i = 0; i < 24; i++) begin
            l[23-i] = sd[1+i];
            r[23-i] = sd[33+i];
        end
        if (sd[0] !== 1'b0) fmt_ok = 1'b0;
        for (int i = 25; i < 33; i++) if (sd[i] !== 1'b0) fmt_ok = 1'b0;
        for (int i = 57; i < 64; i++) if (sd[i] !== 1'b0) fmt_ok = 1'b0;
        for (int i = 0; i < 64; i++) if (lr[i] !== (i >= 32)) fmt_ok = 1'b0;
        check("frame_format", 64'(fmt_ok), 64'd1);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_frame: got %0h expected no frame", {l, r});
        end else begin
            check("frame_data", 64'({l, r}), 64'(exp_q.pop_front()));
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            run_len    = 0;
            slot       = 0;
            idle_cnt   = 0;
            prev_bclk  = 1'b0;
            prev_lrck  = 1'b0;
            prev_sdata = 1'b0;
        end else begin
            if (fifo_read) begin
                read_cnt++;
                run_len++;
            end else if (run_len != 0) begin
                check("read_burst_len", 64'(run_len), 64'd6);
                run_len = 0;
            end
            if ((dac_lrck !== prev_lrck || dac_sdata !== prev_sdata) && !(prev_bclk && !dac_bclk))
                edge_viol++;
            gap++;
            if (!prev_bclk && dac_bclk) begin
                if (slot > 0) check("bclk_period", 64'(gap), 64'(2 * CLK_DIV));
                gap      = 0;
                sd[slot] = dac_sdata;
                lr[slot] = dac_lrck;
                slot++;
                if (slot == 64) begin
                    frame_done();
                    slot = 0;
                    frames_done++;
                end
            end
            idle_cnt = dac_bclk ? 0 : idle_cnt + 1;
            if (idle_cnt > 3 * CLK_DIV) slot = 0;
            prev_bclk  = dac_bclk;
            prev_lrck  = dac_lrck;
            prev_sdata = dac_sdata;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        enable       = 1'b0;
        underrun_clr = 1'b0;
        ptr_clr      = 1'b1;
        tick(3);
        reset   = 1'b0;
        ptr_clr = 1'b0;
        exp_q.delete();
        tick(2);
    endtask

    function automatic logic [7:0] pair_byte(input logic [23:0] l, input logic [23:0] r, input int p);
        logic [47:0] w;
        w = {l, r};
        return w[47-8*p -: 8];
    endfunction

    task automatic load_mem(input logic [23:0] l, input logic [23:0] r);
        for (int i = 0; i < MEM_SIZE; i++) mem[i] = pair_byte(l, r, i % 6);
    endtask

    task automatic wait_slot(input int frames_target, input int s, input string name);
        int t;
        t = 0;
        while (!(frames_done >= frames_target && slot >= s)) begin
            @(negedge clk);
            #1;
            t++;
            if (t > 4000) begin
                fail_timeout(name);
                return;
            end
        end
    endtask

    task automatic wait_stopped(input string name);
        int quiet;
        int t;
        quiet = 0;
        t     = 0;
        while (quiet < 40) begin
            @(negedge clk);
            #1;
            quiet = dac_bclk ? 0 : quiet + 1;
            t++;
            if (t > 4000) begin
                fail_timeout(name);
                return;
            end
        end
    endtask

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        logic [10:0] count;
        logic [47:0] exp_frame;
        logic        exp_ur;
        int          exp_reads;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int base_r;
        int base_f;
        int t;

        vecs[0] = '{24'h123456, 24'hABCDEF, 11'd12,   48'h123456ABCDEF, 1'b0, 12};
        vecs[1] = '{24'h800000, 24'h7FFFFF, 11'd6,    48'h8000007FFFFF, 1'b0, 12};
        vecs[2] = '{24'h123456, 24'hABCDEF, 11'd5,    48'h000000000000, 1'b1, 0};
        vecs[3] = '{24'hFFFFFF, 24'h000001, 11'd2047, 48'hFFFFFF000001, 1'b0, 12};
        vecs[4] = '{24'h5A5A5A, 24'hA5A5A5, 11'd0,    48'h000000000000, 1'b1, 0};
        vecs[5] = '{24'hC3C3C3, 24'h3C3C3C, 11'd7,    48'hC3C3C33C3C3C, 1'b0, 12};

        // Reset state.
        reset        = 1'b1;
        enable       = 1'b1;
        underrun_clr = 1'b0;
        ptr_clr      = 1'b1;
        tick(4);
        check("reset_fifo_read", 64'(fifo_read), 64'd0);
        check("reset_bclk", 64'(dac_bclk), 64'd0);
        check("reset_lrck", 64'(dac_lrck), 64'd0);
        check("reset_sdata", 64'(dac_sdata), 64'd0);
        check("reset_underrun", 64'(underrun), 64'd0);
        enable = 1'b0;
        do_reset();

        // Two data frames from a 12-byte FIFO, then the drained FIFO underruns.
        load_mem(24'h123456, 24'hABCDEF);
        fill    = 12;
        use_ovr = 1'b0;
        base_r  = read_cnt;
        base_f  = frames_done;
        exp_q.push_back(48'h123456ABCDEF);
        exp_q.push_back(48'h123456ABCDEF);
        exp_q.push_back(48'h0);
        enable = 1'b1;
        wait_slot(base_f + 2, 10, "stream_drop_point");
        enable = 1'b0;
        wait_stopped("stream_stop");
        check("stream_reads", 64'(read_cnt - base_r), 64'd12);
        check("stream_frames", 64'(frames_done - base_f), 64'd3);
        check("stream_exp_q_empty", 64'(exp_q.size()), 64'd0);
        check("stream_underrun", 64'(underrun), 64'd1);
        underrun_clr = 1'b1;
        tick(1);
        underrun_clr = 1'b0;
        #1;
        check("stream_underrun_clr", 64'(underrun), 64'd0);

        // Vector table: single frame, enable dropped at bclk 10 of frame 0.
        use_ovr = 1'b1;
        for (int v = 0; v < 6; v++) begin
            do_reset();
            check("vec_reset_underrun", 64'(underrun), 64'd0);
            load_mem(vecs[v].l, vecs[v].r);
            count_ovr = vecs[v].count;
            base_r    = read_cnt;
            base_f    = frames_done;
            exp_q.push_back(vecs[v].exp_frame);
            enable = 1'b1;
            wait_slot(base_f, 10, "vec_drop_point");
            enable = 1'b0;
            wait_stopped("vec_stop");
            check("vec_frames", 64'(frames_done - base_f), 64'd1);
            check("vec_reads", 64'(read_cnt - base_r), 64'(vecs[v].exp_reads));
            check("vec_underrun", 64'(underrun), 64'(vecs[v].exp_ur));
            check("vec_exp_q_empty", 64'(exp_q.size()), 64'd0);
            check("vec_idle_outputs", 64'({dac_bclk, dac_lrck, dac_sdata}), 64'd0);
            base_r = read_cnt;
            tick(300);
            check("vec_no_reads_idle", 64'(read_cnt - base_r), 64'd0);
        end

        // Underrun with 5 bytes, then data once the FIFO holds 6; flag stays sticky.
        do_reset();
        load_mem(24'h123456, 24'hABCDEF);
        count_ovr = 11'd5;
        base_r    = read_cnt;
        base_f    = frames_done;
        exp_q.push_back(48'h0);
        exp_q.push_back(48'h0);
        exp_q.push_back(48'h123456ABCDEF);
        exp_q.push_back(48'h123456ABCDEF);
        enable = 1'b1;
        wait_slot(base_f, 2, "recover_first_frame");
        check("recover_underrun_set", 64'(underrun), 64'd1);
        check("recover_no_reads", 64'(read_cnt - base_r), 64'd0);
        count_ovr = 11'd6;
        wait_slot(base_f + 3, 10, "recover_drop_point");
        enable = 1'b0;
        wait_stopped("recover_stop");
        check("recover_frames", 64'(frames_done - base_f), 64'd4);
        check("recover_reads", 64'(read_cnt - base_r), 64'd18);
        check("recover_exp_q_empty", 64'(exp_q.size()), 64'd0);
        check("recover_underrun_sticky", 64'(underrun), 64'd1);
        underrun_clr = 1'b1;
        tick(1);
        underrun_clr = 1'b0;
        #1;
        check("recover_underrun_clr", 64'(underrun), 64'd0);

        // Reset on the third fetch clk aborts the fetch.
        do_reset();
        count_ovr = 11'd12;
        base_r    = read_cnt;
        enable    = 1'b1;
        t         = 0;
        while (read_cnt - base_r < 3 && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (read_cnt - base_r < 3) fail_timeout("abort_third_read");
        reset = 1'b1;
        #1;
        check("abort_outputs", 64'({fifo_read, dac_bclk, dac_lrck, dac_sdata, underrun}), 64'd0);
        tick(20);
        check("abort_read_count", 64'(read_cnt - base_r), 64'd3);
        enable = 1'b0;
        reset  = 1'b0;
        tick(5);

        check("lrck_sdata_on_bclk_fall", 64'(edge_viol), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/slot_dac_serializer.md
SLOT_DAC_SERIALIZER -- requirements
Module: slot_dac_serializer

Interface
REQ-001 Parameter CLK_DIV, default 4: clk cycles per bclk half-period; legal range 2..255.
REQ-002 Parameter MIN_BYTES, default 6: minimum FIFO byte count that permits a frame fetch.
REQ-003 Port clk  input  1  the single system clock; all logic is on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port enable  input  1  high = run the serial output; low = return to idle at the next frame boundary.
REQ-006 Port fifo_data  input  8  byte from the RAM->DAC tracking FIFO; valid one clk after fifo_read is high.
REQ-007 Port fifo_count  input  11  bytes currently held in the tracking FIFO (addr_in minus addr_out, mod 2048).
REQ-008 Port fifo_read  output  1  one-clk read strobe to the FIFO, one per byte.
REQ-009 Port dac_bclk  output  1  serial bit clock.
REQ-010 Port dac_lrck  output  1  word select: 0 = left, 1 = right.
REQ-011 Port dac_sdata  output  1  serial data.
REQ-012 Port underrun  output  1  sticky flag; set when a frame was zero-filled.
REQ-013 Port underrun_clr  input  1  one-clk pulse that clears underrun.

Function
REQ-014 The bclk divider shall toggle dac_bclk every CLK_DIV clk cycles while running; dac_bclk shall be held at 0 when idle.
REQ-015 Frame format: 64 bclk per frame, 32 per channel, I2S with a 1-bclk delay, 24-bit two's-complement sample sent MSB first, 8 trailing zero bits.
REQ-016 dac_lrck and dac_sdata shall change only on the clk edge that drives dac_bclk 1->0.
REQ-017 Byte order per frame: L[23:16], L[15:8], L[7:0], R[23:16], R[15:8], R[7:0].
REQ-018 Fetch FSM states: IDLE, CHECK, FETCH, HOLD.
REQ-019 IDLE -> CHECK when enable is high; the first frame shall start on the clk after the first fetch completes or zero-fill is decided.
REQ-020 CHECK, when fifo_count >= MIN_BYTES: go to FETCH.
REQ-021 CHECK, when fifo_count < MIN_BYTES: load zeros into the staging buffer, set underrun, go to HOLD, and issue no reads.
REQ-022 FETCH shall assert fifo_read for exactly 6 consecutive clks, capture each byte one clk later into the staging buffer, then go to HOLD; the total is 7 clks.
REQ-023 HOLD: at a frame boundary, transfer the staging buffer to the shift register, then go to CHECK, or to IDLE if enable is low.
REQ-024 Double buffering: the samples for frame N+1 are fetched during frame N.
REQ-025 CLK_DIV >= 2 guarantees the fetch time (8 clks max) fits within one frame (256 clks minimum).
REQ-026 fifo_read shall never be asserted outside FETCH; the total read count shall equal 6 x the number of non-underrun frames.
REQ-027 Partial samples are forbidden: a fetch is either 6 bytes or 0 bytes.
REQ-028 fifo_count is treated as a snapshot in CHECK; bytes arriving during FETCH do not alter the fetch.
REQ-029 If underrun_clr and a new underrun event occur in the same clk, set shall win.
REQ-030 enable falling mid-frame: the current frame completes; then dac_bclk, dac_lrck and dac_sdata go to 0 and the FSM returns to IDLE. A staged but unsent frame is discarded; bytes already read are not returned.

Reset
REQ-031 While reset is high, the FSM shall be in IDLE.
REQ-032 While reset is high, fifo_read, dac_bclk, dac_lrck, dac_sdata and underrun shall be 0.
REQ-033 While reset is high, the divider, bit counter, staging buffer and shift register shall be cleared.
REQ-034 Reset asserted mid-FETCH shall abort the fetch immediately with no further reads.
REQ-035 After reset deasserts, the block shall resume only through IDLE -> CHECK.

Structure
REQ-036 A shared package shall hold the FSM state encoding, the frame constants (BITS_PER_CHANNEL = 32, SAMPLE_BITS = 24, BYTES_PER_FRAME = 6) and the fifo_count width (11).
REQ-037 One sub-module, slot_bclk_divider, shall produce the bclk level plus one-clk rise and fall strobes; everything else is flat.

Verification
REQ-038 With CLK_DIV = 4, a FIFO preloaded with 12 bytes (L = 0x123456, R = 0xABCDEF, repeated) and enable = 1, the bench shall see bclk period = 8 clks, serial data 0x123456 then 0xABCDEF per I2S framing, and exactly 12 reads.
REQ-039 With fifo_count = 5 and enable = 1, the bench shall see zero reads, a zero-filled frame and underrun = 1.
REQ-040 After REQ-039, raising fifo_count to 6 shall cause the next frame to carry data while underrun stays 1 until underrun_clr is pulsed.
REQ-041 With fifo_count = 6 held constant during FETCH, the bench shall see exactly 6 consecutive fifo_read pulses and data capture one clk after each pulse.
REQ-042 Dropping enable at bclk 10 of a frame shall complete the frame (64 bclk total), then hold all outputs at 0 and issue no further reads.
REQ-043 Asserting reset on the 3rd fetch clk shall drive all outputs to 0 immediately and leave the read count at 3.
